// File: rtl/lsu_byte_serial_if.sv
// Request/response bundle between the execute stage and the
// byte-serial load/store unit.
interface lsu_byte_serial_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [1:0]               dataType;
    logic                     req_unsigned;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;
    logic                     resp_valid;
    logic                     resp_err;
    logic [DATA_WIDTH-1:0]    resp_rdata;

    modport master (
        output req_valid, req_we, dataType, req_unsigned,
        output req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, dataType, req_unsigned,
        input  req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/lsu_byte_serial.sv
// Byte-serial load/store initiator: splits word/half/byte accesses
// into single-byte memory cycles and assembles little-endian loads.
module lsu_byte_serial #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    lsu_byte_serial_if.slave         bus,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [BYTE_WIDTH-1:0]    mem_wdata,
    input  logic [BYTE_WIDTH-1:0]    mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                   state;
    logic                     we;
    logic                     uns;
    logic [1:0]               idx;
    logic [1:0]               last;
    logic [ADDRESS_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH-1:0]    rbuf;
    logic                     resp_valid;
    logic                     resp_err;
    logic [DATA_WIDTH-1:0]    resp_rdata;

    logic [1:0]               req_last;
    logic                     req_bad;
    logic [1:0]               idx_nxt;
    logic [DATA_WIDTH-1:0]    rbuf_nxt;
    logic [DATA_WIDTH-1:0]    ext;

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid;
    assign bus.resp_err   = resp_err;
    assign bus.resp_rdata = resp_rdata;

    assign idx_nxt = idx + 2'd1;

    // Decode byte count (as last index) and alignment/type errors.
    always_comb begin
        req_last = 2'd0;
        req_bad  = 1'b0;
        unique case (bus.dataType)
            2'b00: begin
                req_last = 2'd3;
                req_bad  = |bus.req_addr[1:0];
            end
            2'b10: begin
                req_last = 2'd1;
                req_bad  = bus.req_addr[0];
            end
            2'b01: req_last = 2'd0;
            default: req_bad = 1'b1;
        endcase
    end

    // Merge the current read byte and extend from the top loaded byte.
    always_comb begin
        rbuf_nxt = rbuf;
        rbuf_nxt[32'(idx)*BYTE_WIDTH +: BYTE_WIDTH] = mem_rdata;
        unique case (last)
            2'd0: ext = {{(DATA_WIDTH-8){~uns & rbuf_nxt[7]}},
                         rbuf_nxt[7:0]};
            2'd1: ext = {{(DATA_WIDTH-16){~uns & rbuf_nxt[15]}},
                         rbuf_nxt[15:0]};
            default: ext = rbuf_nxt;
        endcase
    end

    // Control FSM with registered memory and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            last       <= 2'd0;
            we         <= 1'b0;
            uns        <= 1'b0;
            base       <= '0;
            wdata      <= '0;
            rbuf       <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we    <= bus.req_we;
                        uns   <= bus.req_unsigned;
                        base  <= bus.req_addr;
                        wdata <= bus.req_wdata;
                        last  <= req_last;
                        idx   <= 2'd0;
                        if (req_bad) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ACCESS;
                            mem_en    <= 1'b1;
                            mem_we    <= bus.req_we;
                            mem_addr  <= bus.req_addr;
                            mem_wdata <= bus.req_wdata[BYTE_WIDTH-1:0];
                        end
                    end
                end
                ACCESS: begin
                    if (!we) rbuf <= rbuf_nxt;
                    if (idx == last) begin
                        state      <= DONE;
                        mem_en     <= 1'b0;
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= we ? '0 : ext;
                    end else begin
                        idx       <= idx_nxt;
                        mem_addr  <= base + ADDRESS_WIDTH'(idx_nxt);
                        mem_wdata <=
                            wdata[32'(idx_nxt)*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_byte_serial.sv
// Directed bench for lsu_byte_serial: byte-array memory model,
// per-request access trace and hand-computed expectations.
module tb_lsu_byte_serial;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic        poke_en = 1'b0;
    logic [13:0] poke_addr = '0;
    logic [7:0]  poke_data = '0;
    logic [7:0]  mem [0:16383];

    int checks = 0;
    int failures = 0;

    logic [31:0] acc_addr [$];
    logic        acc_we [$];
    logic [7:0]  acc_wdata [$];
    logic [31:0] r_data;
    logic        r_err;
    int          r_lat;
    logic [31:0] b2b_data [$];
    int          b2b_when [$];
    int          accept_k;
    int          saw_resp;

    lsu_byte_serial_if bus ();

    lsu_byte_serial dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[13:0]];

    // Byte memory: bench pokes for preload, DUT writes otherwise.
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (mem_en && mem_we) mem[mem_addr[13:0]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [13:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic run_req(input logic we, input logic [1:0] dt,
                           input logic uns, input logic [31:0] addr,
                           input logic [31:0] wd);
        bit got;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.dataType = dt;
        bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
        acc_addr.delete(); acc_we.delete(); acc_wdata.delete();
        got = 0; r_lat = 0; r_data = 'x; r_err = 1'bx;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (mem_en) begin
                acc_addr.push_back(mem_addr);
                acc_we.push_back(mem_we);
                acc_wdata.push_back(mem_wdata);
            end
            if (bus.resp_valid) begin
                got = 1; r_lat = k;
                r_data = bus.resp_rdata; r_err = bus.resp_err;
            end
        end
        if (!got) check("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.dataType = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;

        poke(14'h1000, 8'h78); poke(14'h1001, 8'h56);
        poke(14'h1002, 8'h34); poke(14'h1003, 8'h12);
        poke(14'h2000, 8'h11); poke(14'h2001, 8'h22);
        poke(14'h2002, 8'h33); poke(14'h2003, 8'h44);

        // LW 0x1000
        run_req(1'b0, 2'b00, 1'b0, 32'h1000, 32'h0);
        check("lw_ncyc", 32'(acc_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
            check("lw_addr", acc_addr[i], 32'h1000 + 32'(i));
            check("lw_we", 32'(acc_we[i]), 32'd0);
        end
        check("lw_lat", 32'(r_lat), 32'd5);
        check("lw_err", 32'(r_err), 32'd0);
        check("lw_data", r_data, 32'h12345678);

        // LB / LBU of 0x80
        poke(14'h1003, 8'h80);
        run_req(1'b0, 2'b01, 1'b0, 32'h1003, 32'h0);
        check("lb_ncyc", 32'(acc_addr.size()), 32'd1);
        check("lb_lat", 32'(r_lat), 32'd2);
        check("lb_data", r_data, 32'hFFFFFF80);
        run_req(1'b0, 2'b01, 1'b1, 32'h1003, 32'h0);
        check("lbu_ncyc", 32'(acc_addr.size()), 32'd1);
        check("lbu_lat", 32'(r_lat), 32'd2);
        check("lbu_data", r_data, 32'h00000080);

        // SH 0x1002
        run_req(1'b1, 2'b10, 1'b0, 32'h1002, 32'hDEADBEEF);
        check("sh_ncyc", 32'(acc_addr.size()), 32'd2);
        if (acc_addr.size() == 2) begin
            check("sh_a0", acc_addr[0], 32'h1002);
            check("sh_d0", 32'(acc_wdata[0]), 32'hEF);
            check("sh_w0", 32'(acc_we[0]), 32'd1);
            check("sh_a1", acc_addr[1], 32'h1003);
            check("sh_d1", 32'(acc_wdata[1]), 32'hBE);
            check("sh_w1", 32'(acc_we[1]), 32'd1);
        end
        check("sh_lat", 32'(r_lat), 32'd3);
        check("sh_err", 32'(r_err), 32'd0);
        check("sh_data", r_data, 32'd0);
        check("sh_m1000", 32'(mem[14'h1000]), 32'h78);
        check("sh_m1001", 32'(mem[14'h1001]), 32'h56);
        check("sh_m1002", 32'(mem[14'h1002]), 32'hEF);
        check("sh_m1003", 32'(mem[14'h1003]), 32'hBE);

        // Misaligned and illegal
        run_req(1'b0, 2'b00, 1'b0, 32'h1002, 32'h0);
        check("lw_mis_err", 32'(r_err), 32'd1);
        check("lw_mis_lat", 32'(r_lat), 32'd1);
        check("lw_mis_en", 32'(acc_addr.size()), 32'd0);
        check("lw_mis_data", r_data, 32'd0);
        run_req(1'b1, 2'b10, 1'b0, 32'h1001, 32'h12345678);
        check("sh_mis_err", 32'(r_err), 32'd1);
        check("sh_mis_lat", 32'(r_lat), 32'd1);
        check("sh_mis_en", 32'(acc_addr.size()), 32'd0);
        run_req(1'b1, 2'b11, 1'b0, 32'h1000, 32'h12345678);
        check("ill_err", 32'(r_err), 32'd1);
        check("ill_lat", 32'(r_lat), 32'd1);
        check("ill_en", 32'(acc_addr.size()), 32'd0);
        check("ill_m1000", 32'(mem[14'h1000]), 32'h78);
        check("ill_m1001", 32'(mem[14'h1001]), 32'h56);

        // Reset in the cycle presenting store byte 1
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.dataType = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h1000;
        bus.req_wdata = 32'hAABBCCDD;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("rs_b0_addr", mem_addr, 32'h1000);
        @(negedge clk);
        check("rs_b1_addr", mem_addr, 32'h1001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rs_ready", 32'(bus.req_ready), 32'd1);
        check("rs_mem_en", 32'(mem_en), 32'd0);
        saw_resp = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.resp_valid) saw_resp++;
            @(negedge clk);
        end
        check("rs_no_resp", 32'(saw_resp), 32'd0);
        check("rs_m1000", 32'(mem[14'h1000]), 32'hDD);
        check("rs_m1001", 32'(mem[14'h1001]), 32'hCC);
        check("rs_m1002", 32'(mem[14'h1002]), 32'hEF);
        check("rs_m1003", 32'(mem[14'h1003]), 32'hBE);
        run_req(1'b0, 2'b00, 1'b0, 32'h2000, 32'h0);
        check("rs_lw_lat", 32'(r_lat), 32'd5);
        check("rs_lw_data", r_data, 32'h44332211);

        // Back-to-back LB then LW with req_valid held high
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.dataType = 2'b01;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h2003;
        accept_k = 0;
        b2b_data.delete(); b2b_when.delete();
        for (int k = 1; k <= 20 && b2b_data.size() < 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.dataType = 2'b00; bus.req_addr = 32'h2000;
            end
            if (accept_k != 0) bus.req_valid = 1'b0;
            if (bus.req_ready && accept_k == 0 && k > 0) accept_k = k;
            if (k <= 2) check("b2b_busy", 32'(bus.req_ready), 32'd0);
            if (bus.resp_valid) begin
                b2b_data.push_back(bus.resp_rdata);
                b2b_when.push_back(k);
            end
        end
        bus.req_valid = 1'b0;
        check("b2b_accept", 32'(accept_k), 32'd3);
        check("b2b_nresp", 32'(b2b_data.size()), 32'd2);
        if (b2b_data.size() == 2) begin
            check("b2b_lb_when", 32'(b2b_when[0]), 32'd2);
            check("b2b_lb_data", b2b_data[0], 32'h00000044);
            check("b2b_lw_when", 32'(b2b_when[1]), 32'd8);
            check("b2b_lw_data", b2b_data[1], 32'h44332211);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_byte_serial.md
Name: lsu_byte_serial

Overview:
- Load/store initiator between the execute stage and the byte-addressed data memory.
- Accepts one word, halfword or byte load/store request from the core.
- Issues it to a byte-wide memory port as a sequence of single-byte accesses, assembling little-endian read data with sign or zero extension.
- Returns a one-cycle completion response; misaligned requests are rejected without touching memory.

Parameters:
- ADDRESS_WIDTH, 32, width of request and memory addresses.
- DATA_WIDTH, 32, core data width; fixed at 32 for this block.
- BYTE_WIDTH, 8, width of the memory data port.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- dataType  input  2  00 word, 01 byte, 10 halfword, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDRESS_WIDTH  byte address (ALU result).
- req_wdata  input  DATA_WIDTH  store data (rd2).
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  valid with resp_valid; 1 = misaligned or illegal type.
- resp_rdata  output  DATA_WIDTH  extended load data.
- mem_en  output  1  memory access active this cycle.
- mem_we  output  1  byte write enable.
- mem_addr  output  ADDRESS_WIDTH  byte address to memory.
- mem_wdata  output  BYTE_WIDTH  byte to write.
- mem_rdata  input  BYTE_WIDTH  asynchronous read byte, valid in the same cycle as mem_addr.

Behaviour:
- Reset (rst=1 at a clk edge):
  - State goes to IDLE, byte index to 0.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation:
  - Returns to IDLE at that edge; no response is generated.
  - Store bytes already written stay written.
  - req_ready=1 in the following cycle.
- States are IDLE, ACCESS and DONE.
  - req_ready = (state==IDLE), decoded directly from the state register.
  - req_valid while not ready is ignored; no queuing.
- IDLE:
  - On req_valid at an edge, latch we, dataType, unsigned, addr and wdata; clear the byte index.
  - Byte count N is 4 for word, 2 for halfword, 1 for byte.
  - Error condition: dataType==11, or word with addr[1:0]!=0, or halfword with addr[0]!=0.
  - On error go to DONE with the error flag set. Otherwise go to ACCESS.
- ACCESS, byte index i from 0 to N-1:
  - Drive mem_en=1, mem_addr=base+i (modulo 2^ADDRESS_WIDTH), mem_we=latched we.
  - mem_wdata = wdata byte i, i.e. bits [8i+7:8i] (little-endian).
  - On a load, capture mem_rdata into buffer byte i at the clock edge.
  - At i==N-1, go to DONE; otherwise increment i.
- Outside ACCESS, mem_en=0 and mem_we=0; mem_addr and mem_wdata are don't-care but deterministic.
- DONE:
  - resp_valid=1 for exactly one cycle; resp_err = error flag; then return to IDLE.
  - Load, no error: resp_rdata is the buffer extended from bit 8N-1, replicated for signed and zero-filled for unsigned.
  - Store, or any error: resp_rdata=0.
  - resp_rdata holds its value until the next DONE.
- Latency, with the request accepted at edge E:
  - Memory byte accesses occupy cycles E+1 through E+N.
  - resp_valid is high in cycle E+N+1.
  - Error case: resp_valid is high in cycle E+1 and mem_en is never asserted.
  - Next request accepted at the edge ending the DONE cycle + 1, so throughput is one request per N+2 cycles.
- Alignment is enforced, so an accepted access never crosses the top of the address space.

Test Plan:
- Aligned word load: LW at 0x1000, memory holds 78,56,34,12 at 0x1000..0x1003.
  - Required: mem_en high 4 cycles with addrs 0x1000..0x1003, mem_we=0.
  - Then resp_valid=1, resp_err=0, resp_rdata=0x12345678.
- Byte load extension: address 0x1003 holds 0x80.
  - Signed byte load -> resp_rdata=0xFFFFFF80.
  - Unsigned byte load -> resp_rdata=0x00000080.
  - Each takes 1 mem cycle; resp_valid 2 cycles after acceptance.
- Halfword store: SH 0x1002, req_wdata=0xDEADBEEF.
  - Required: two write cycles, (0x1002, 0xEF) then (0x1003, 0xBE).
  - Then resp_valid=1, resp_rdata=0; 0x1000/0x1001 unchanged.
- Misaligned and illegal requests: LW at 0x1002, SH at 0x1001, dataType=11.
  - Required: each gives resp_valid=1 and resp_err=1 the cycle after acceptance.
  - mem_en stays 0 and memory is unchanged.
- Reset mid-store: SW 0x1000, wdata 0xAABBCCDD; assert rst for the edge after byte 1 is written.
  - Required: only 0xDD and 0xCC written, no resp_valid.
  - req_ready=1 next cycle; a following LW at 0x2000 completes normally.
- Back-to-back: req_valid held high with LB then LW.
  - Required: req_ready low during ACCESS/DONE; second request accepted exactly 3 cycles after the first.
  - Both responses are correct and in order.
